ifu_fetch: RTL

Instruction-fetch unit at the front of the single-issue core; the consuming end of the branch-resolution path in the IDU. Holds the architectural PC and issues one fetch per instruction over a valid/ready memory request and response channel. Hands the instruction to the IDU, then loads the next PC (`dnpc`) returned by the IDU's branch unit before fetching again. Strictly one instruction in flight.

---
 rtl/ifu_fetch_pkg.sv | 28 ++
 rtl/ifu_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction-fetch unit.
//   state_e           : 3-bit FSM state encoding.
//   RST_N_ENABLE      : level of rst that holds the unit in reset.
//   DEFAULT_RESET_PC  : boot PC, matches the branch unit's reset dnpc.
//   INST_ADDR_W       : PC / instruction-address width.
package ifu_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;

  localparam logic                   RST_N_ENABLE     = 1'b0;
  localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_NEXT = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: holds the architectural PC and fetches one instruction at a time.
// Ports:
//   clk, rst              : core clock, asynchronous active-low reset
//   req_valid_o/ready_i   : fetch request handshake, req_addr_o == pc_o
//   rsp_valid_i/data_i    : instruction response, taken only while waiting
//   inst_valid_o/ready_i  : registered instruction handed to the IDU (inst_o)
//   pc_o                  : PC of the current fetch / instruction
//   dnpc_valid_i, dnpc_i  : resolved next PC from the IDU branch unit
//   misalign_o            : sticky, a misaligned dnpc was received (unit halts)
//   inst_cnt_o            : completed IDU handshakes, wrapping
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = INST_ADDR_W,
  parameter int unsigned     INST_W   = INST_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              dnpc_valid_i,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic              misalign_o,
  output logic [31:0]       inst_cnt_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                misalign_q, misalign_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                req_valid_q, req_valid_d;
  logic                inst_valid_q, inst_valid_d;
  logic                take;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_N_ENABLE) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misalign_q   <= misalign_d;
      cnt_q        <= cnt_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    take       = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (req_ready_i) state_d = S_WAIT;
      S_WAIT: begin
        if (rsp_valid_i) begin
          inst_d  = rsp_data_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready_i) begin
          cnt_d = cnt_q + 32'd1;
          if (dnpc_valid_i) take = 1'b1;
          else              state_d = S_NEXT;
        end
      end
      S_NEXT: if (dnpc_valid_i) take = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // A misaligned target keeps the old PC and parks the unit.
    if (take) begin
      if (is_aligned(dnpc_i[1:0])) begin
        pc_d    = dnpc_i;
        state_d = S_REQ;
      end else begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end
    end

    // Handshake flags are registered copies of the upcoming state.
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
  end

  assign req_valid_o  = req_valid_q;
  assign req_addr_o   = pc_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign misalign_o   = misalign_q;
  assign inst_cnt_o   = cnt_q;

endmodule
